// File: rtl/rr_arb_pkg.sv
// Shared types and helpers for the round-robin lock arbiter.
//   state_t      : arbiter FSM state (IDLE / GRANT)
//   N_DEF        : default requester count
//   MAX_HOLD_DEF : default hold limit for the optional timeout
//   idw_f()      : width of a binary index into N requesters
package rr_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam int N_DEF        = 4;
    localparam int MAX_HOLD_DEF = 16;

    function automatic int idw_f(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational rotating-priority pick.
// Scans cand starting at ptr upward, wrapping to 0, where cand is req with
// an optional single bit masked out. Implemented as a two-pass masked
// priority: first the bits at or above ptr, then the whole vector.
// Ports:
//   req      in  N    request vector
//   ptr      in  IDW  first index to scan
//   mask_en  in  1    drop bit mask_idx from consideration
//   mask_idx in  IDW  index to drop
//   pick     out N    one-hot winner (zero when none)
//   pick_id  out IDW  binary index of winner (zero when none)
//   vld      out 1    any candidate present
module rr_pick
    import rr_arb_pkg::*;
#(
    parameter int N   = N_DEF,
    parameter int IDW = idw_f(N)
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] ptr,
    input  logic           mask_en,
    input  logic [IDW-1:0] mask_idx,
    output logic [N-1:0]   pick,
    output logic [IDW-1:0] pick_id,
    output logic           vld
);

    logic [N-1:0] cand;
    logic [N-1:0] upper;
    logic [N-1:0] sel;
    logic         found;

    always_comb begin
        cand    = '0;
        upper   = '0;
        pick    = '0;
        pick_id = '0;
        found   = 1'b0;
        for (int i = 0; i < N; i++) begin
            cand[i]  = req[i] & ~(mask_en && (mask_idx == IDW'(i)));
            upper[i] = cand[i] && (i >= int'(ptr));
        end
        // Nothing at or above ptr means the scan wraps to index 0.
        sel = (|upper) ? upper : cand;
        for (int i = 0; i < N; i++) begin
            if (sel[i] && !found) begin
                pick[i] = 1'b1;
                pick_id = IDW'(i);
                found   = 1'b1;
            end
        end
        vld = |cand;
    end

endmodule

// File: rtl/rr_lock_arbiter.sv
// Round-robin arbiter with grant locking. The owner keeps the registered
// one-hot grant until it drops its request; on release the pointer moves
// past the owner and a new owner is picked in the same edge (no bubble).
// Optional feature macro: RR_LOCK_ARBITER_TIMEOUT_EN
//   adds a hold counter that revokes an owner after MAX_HOLD grant cycles
//   when someone else is waiting, plus a one-cycle `timeout` pulse.
// Ports:
//   clk     in  1    rising-edge clock
//   rst     in  1    synchronous active-high reset
//   req     in  N    request levels
//   gnt     out N    registered one-hot grant
//   gnt_id  out IDW  index of owner, 0 when idle
//   busy    out 1    |gnt
//   timeout out 1    revoke pulse (only with RR_LOCK_ARBITER_TIMEOUT_EN)
module rr_lock_arbiter
    import rr_arb_pkg::*;
#(
    parameter  int N        = N_DEF,
    parameter  int MAX_HOLD = MAX_HOLD_DEF,
    localparam int IDW      = idw_f(N)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   req,
    output logic [N-1:0]   gnt,
    output logic [IDW-1:0] gnt_id,
    output logic           busy
`ifdef RR_LOCK_ARBITER_TIMEOUT_EN
    ,
    output logic           timeout
`endif
);

    if (N < 2 || N > 32) begin : g_bad_n
        $error("rr_lock_arbiter: N out of range 2..32");
    end
    if (MAX_HOLD < 2 || MAX_HOLD > 65535) begin : g_bad_hold
        $error("rr_lock_arbiter: MAX_HOLD out of range 2..65535");
    end

    state_t         state;
    logic [IDW-1:0] ptr;
    logic [IDW-1:0] nxt_ptr;
    logic           owner_req;
    logic           rel;
    logic           revoke;
    logic           handoff;
    logic [N-1:0]   pick;
    logic [IDW-1:0] pick_id;
    logic           pick_vld;

    assign owner_req = req[gnt_id];
    assign rel       = (state == GRANT) && !owner_req;
    assign handoff   = rel | revoke;
    assign nxt_ptr   = (gnt_id == IDW'(N - 1)) ? '0 : gnt_id + 1'b1;
    assign busy      = |gnt;

`ifdef RR_LOCK_ARBITER_TIMEOUT_EN
    localparam logic [15:0] HOLD_LAST = 16'(MAX_HOLD - 1);
    logic [15:0] hold_cnt;
    // Revoke only when the owner still wants the resource and someone
    // else is waiting; otherwise the counter just saturates.
    assign revoke = (state == GRANT) && owner_req && (hold_cnt == HOLD_LAST)
                    && |(req & ~gnt);
`else
    assign revoke = 1'b0;
`endif

    // On handoff the old owner is masked so it cannot win again at the
    // same edge, even if its request is still (or again) high.
    rr_pick #(.N(N), .IDW(IDW)) u_pick (
        .req     (req),
        .ptr     (handoff ? nxt_ptr : ptr),
        .mask_en (handoff),
        .mask_idx(gnt_id),
        .pick    (pick),
        .pick_id (pick_id),
        .vld     (pick_vld)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            ptr    <= '0;
            gnt    <= '0;
            gnt_id <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_vld) begin
                        gnt    <= pick;
                        gnt_id <= pick_id;
                        state  <= GRANT;
                    end
                end
                GRANT: begin
                    if (handoff) begin
                        ptr <= nxt_ptr;
                        if (pick_vld) begin
                            gnt    <= pick;
                            gnt_id <= pick_id;
                        end else begin
                            gnt    <= '0;
                            gnt_id <= '0;
                            state  <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef RR_LOCK_ARBITER_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_cnt <= '0;
            timeout  <= 1'b0;
        end else begin
            timeout <= revoke;
            if ((state == IDLE) || handoff) begin
                hold_cnt <= '0;
            end else if (hold_cnt != HOLD_LAST) begin
                hold_cnt <= hold_cnt + 16'd1;
            end
        end
    end
`endif

    a_onehot_gnt: assert property (@(posedge clk) disable iff (rst) $onehot0(gnt));

endmodule

// File: tb/tb_rr_lock_arbiter.sv
module tb_rr_lock_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] gnt_id;
    logic       busy;
`ifdef RR_LOCK_ARBITER_TIMEOUT_EN
    logic       timeout;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    rr_lock_arbiter #(.N(4), .MAX_HOLD(4)) dut (
        .clk    (clk),
        .rst    (rst),
        .req    (req),
        .gnt    (gnt),
        .gnt_id (gnt_id),
        .busy   (busy)
`ifdef RR_LOCK_ARBITER_TIMEOUT_EN
        ,
        .timeout(timeout)
`endif
    );

    // Apply inputs, take one rising edge, sample 1 time unit later.
    task automatic tick(input logic r, input logic [3:0] rq);
        rst = r;
        req = rq;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [3:0] eg, input logic [1:0] eid,
                       input logic eb);
        total++;
        assert (gnt === eg) else begin
            bad++;
            $error("FAIL %s gnt got=%b exp=%b", tag, gnt, eg);
        end
        total++;
        assert (gnt_id === eid) else begin
            bad++;
            $error("FAIL %s gnt_id got=%0d exp=%0d", tag, gnt_id, eid);
        end
        total++;
        assert (busy === eb) else begin
            bad++;
            $error("FAIL %s busy got=%b exp=%b", tag, busy, eb);
        end
    endtask

`ifdef RR_LOCK_ARBITER_TIMEOUT_EN
    task automatic chk_to(input string tag, input logic et);
        total++;
        assert (timeout === et) else begin
            bad++;
            $error("FAIL %s timeout got=%b exp=%b", tag, timeout, et);
        end
    endtask
`endif

    initial begin
        rst = 1'b1;
        req = 4'b0000;
        @(negedge clk);

        // reset with everyone requesting
        tick(1, 4'b1111); chk("rst0", 4'b0000, 2'd0, 0);
        tick(1, 4'b1111); chk("rst1", 4'b0000, 2'd0, 0);
        tick(0, 4'b1111); chk("first", 4'b0001, 2'd0, 1);

        // release to idle -> ptr=1; idle grant scans 1,2,3,0
        tick(0, 4'b0000); chk("idle", 4'b0000, 2'd0, 0);
        tick(0, 4'b0001); chk("lock_g", 4'b0001, 2'd0, 1);
        tick(0, 4'b0001); chk("lock_h1", 4'b0001, 2'd0, 1);
        tick(0, 4'b0101); chk("lock_h2", 4'b0001, 2'd0, 1);
        tick(0, 4'b0101); chk("lock_h3", 4'b0001, 2'd0, 1);
        tick(0, 4'b0100); chk("lock_rel", 4'b0100, 2'd2, 1);

        // full rotation, no gap cycles
        tick(1, 4'b1111); chk("rst2", 4'b0000, 2'd0, 0);
        tick(0, 4'b1111); chk("rot0", 4'b0001, 2'd0, 1);
        tick(0, 4'b1111); chk("rot0h", 4'b0001, 2'd0, 1);
        tick(0, 4'b1110); chk("rot1", 4'b0010, 2'd1, 1);
        tick(0, 4'b1111); chk("rot1h", 4'b0010, 2'd1, 1);
        tick(0, 4'b1101); chk("rot2", 4'b0100, 2'd2, 1);
        tick(0, 4'b1111); chk("rot2h", 4'b0100, 2'd2, 1);
        tick(0, 4'b1011); chk("rot3", 4'b1000, 2'd3, 1);
        tick(0, 4'b1111); chk("rot3h", 4'b1000, 2'd3, 1);
        tick(0, 4'b0111); chk("rot_wrap", 4'b0001, 2'd0, 1);

        // wrap and skip
        tick(0, 4'b0110); chk("ws1", 4'b0010, 2'd1, 1);
        tick(0, 4'b1100); chk("ws2", 4'b0100, 2'd2, 1);
        tick(0, 4'b1011); chk("ws_skip", 4'b1000, 2'd3, 1);
        tick(0, 4'b0011); chk("ws_wrap", 4'b0001, 2'd0, 1);
        tick(0, 4'b0010); chk("ws_next", 4'b0010, 2'd1, 1);
        // release with nothing pending -> ptr=2, idle grant keeps ptr
        tick(0, 4'b0000); chk("to_idle", 4'b0000, 2'd0, 0);
        tick(0, 4'b1001); chk("idle_ptr", 4'b1000, 2'd3, 1);
        tick(0, 4'b0001); chk("idle_wrap", 4'b0001, 2'd0, 1);

        // reset mid-grant
        tick(0, 4'b0100); chk("mid_pre", 4'b0100, 2'd2, 1);
        tick(1, 4'b0100); chk("mid_rst", 4'b0000, 2'd0, 0);
        tick(0, 4'b0110); chk("mid_post", 4'b0010, 2'd1, 1);
        // park ptr at 2, then reset must return it to 0
        tick(0, 4'b0000); chk("mid_idle", 4'b0000, 2'd0, 0);
        tick(0, 4'b0100); chk("mid_g2", 4'b0100, 2'd2, 1);
        tick(1, 4'b0101); chk("mid_rst2", 4'b0000, 2'd0, 0);
        tick(0, 4'b0101); chk("ptr_reset", 4'b0001, 2'd0, 1);

`ifdef RR_LOCK_ARBITER_TIMEOUT_EN
        tick(1, 4'b0000); chk("to_rst", 4'b0000, 2'd0, 0); chk_to("to_rst", 0);
        tick(0, 4'b0011); chk("to_g", 4'b0001, 2'd0, 1); chk_to("to_g", 0);
        for (int i = 0; i < 3; i++) begin
            tick(0, 4'b0011); chk("to_hold", 4'b0001, 2'd0, 1); chk_to("to_hold", 0);
        end
        tick(0, 4'b0011); chk("to_revoke", 4'b0010, 2'd1, 1); chk_to("to_revoke", 1);
        tick(0, 4'b0011); chk("to_after", 4'b0010, 2'd1, 1); chk_to("to_after", 0);
        tick(0, 4'b0001); chk("to_solo", 4'b0001, 2'd0, 1); chk_to("to_solo", 0);
        for (int i = 0; i < 6; i++) begin
            tick(0, 4'b0001); chk("to_sat", 4'b0001, 2'd0, 1); chk_to("to_sat", 0);
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rr_lock_arbiter.md
Name: rr_lock_arbiter

Overview:
- Sequential round-robin arbiter with grant locking.
- Shares one resource among N requesters; one-hot grant is registered and held until the owner drops its request.
- Rotating-priority pointer gives fairness.
- Combinational fixed-priority pick is the inner selection stage; this block adds state, locking and rotation around it.

Parameters:
- N, 4, number of requesters; legal range 2..32.
- IDW, $clog2(N), width of the grant index; derived, not overridden.
- MAX_HOLD, 16, max consecutive grant cycles per owner; used only with the optional feature; legal range 2..65535.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  reset, synchronous, active-high.
- req  input  N  per-requester request level; held high for the whole transaction.
- gnt  output  N  registered one-hot grant; all-zero when idle.
- gnt_id  output  IDW  binary index of the current owner; 0 when idle.
- busy  output  1  high while any grant is asserted; equals |gnt.

Behaviour:
- Reset: one clock, synchronous, active-high. At the clk edge with rst=1:
  - gnt=0, gnt_id=0, busy=0.
  - rotation pointer ptr=0.
  - state=IDLE.
  - hold counter=0.
- rst overrides all other inputs.
- Reset mid-grant: grant dropped at that edge. No release handshake.
- States:
  - IDLE: no owner. If req!=0 at edge t, pick the first set bit scanning ptr, ptr+1, ..., N-1, 0, ..., ptr-1. gnt/gnt_id/busy valid from edge t (visible cycle t+1). Go to GRANT.
  - GRANT: owner k. While req[k]=1, gnt stays at bit k; other req bits are ignored (lock).
  - Release: req[k]=0 sampled at edge t.
    - ptr <= (k+1) mod N.
    - Re-arbitrate in the same edge using the new ptr, on req with bit k masked.
    - Another request pending: new grant visible at t+1, no idle bubble.
    - None pending: gnt=0 at t+1, state IDLE.
  - The released owner cannot be re-granted at the release edge, even if req[k] re-rises that cycle.
- Fairness: every requester that holds req high is granted within N-1 other grants.
- Latency: request to grant is 1 cycle from IDLE. Release to next grant is 1 cycle.
- ptr changes only on release or revoke, never on an IDLE grant.
- Wrap-around: from ptr=N-1, scan order is N-1 then 0 upward. Modular wrap is required for non-power-of-two N.
- gnt is never multi-hot. A unit-level assertion checks $onehot0(gnt).
- Requests that drop before being granted are simply lost. No queueing.

Optional Feature:
- Macro: RR_LOCK_ARBITER_TIMEOUT_EN
- Defined:
  - Hold counter increments each GRANT cycle and resets on every new grant.
  - Counter reaching MAX_HOLD-1 while any other req bit is high revokes ownership at the next edge. Handling is identical to release (ptr <= k+1, re-arbitrate with k masked).
  - Revoke with no other requester pending: grant kept, counter saturates.
  - Added output `timeout` (1b) pulses for one cycle with the revoke.
- Undefined: no counter, no timeout port; grants held indefinitely.

Decomposition:
- Package rr_arb_pkg:
  - state enum {IDLE, GRANT}.
  - Default constants for N and MAX_HOLD.
  - Function to compute IDW.
- Sub-module rr_pick, combinational: inputs req, ptr, mask-out bit; outputs one-hot pick and index.
  - Implemented as rotate, fixed-priority select, rotate back (or as double-width masked priority).
- Top holds the FSM, ptr, output registers and optional counter.

Test Plan (N=4):
- Reset: rst=1 for 2 cycles with req=1111 -> gnt=0000, gnt_id=0, busy=0. First edge after rst=0 -> gnt=0001.
- Single request and lock: req=0001 at t0 -> gnt=0001 at t0+1. Raise req[2] at t0+3 -> gnt stays 0001. Drop req[0] at t0+5 -> gnt=0100, gnt_id=2 at t0+6.
- Full rotation: req=1111 held; each owner drops for 1 cycle after 2 cycles -> grant order 0001, 0010, 0100, 1000, 0001. No gap cycle between grants.
- Wrap and skip: owner 2 releases with req=1011 -> next gnt=1000. Owner 3 releases with req=0011 -> gnt=0001 (wraps, ptr=0).
- Reset mid-grant: gnt=0100 active, rst=1 one cycle -> gnt=0000 next edge, ptr=0. With req=0110 after reset -> gnt=0010.
- Timeout (macro defined, MAX_HOLD=4): req=0011 held -> gnt=0001 for 4 cycles, then timeout=1 and gnt=0010. With req=0001 only -> gnt=0001 held and no timeout pulse.
